// File: rtl/wb_mux_pkg.sv
// Shared definitions for the write-back source selector: handshake state
// encoding, legal source-count range and the select range check.
package wb_mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int NUM_SRC_MIN = 2;
  localparam int NUM_SRC_MAX = 16;

  function automatic logic sel_in_range(input int sel, input int num_src);
    return (sel < num_src);
  endfunction

endpackage

// File: rtl/wb_skid_reg.sv
// Two-entry skid register with valid/ready on both sides. The upstream ready
// is decoded from state only, so there is no combinational path from downstream.
module wb_skid_reg
  import wb_mux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data
);

  state_e       r_state;
  state_e       w_state_nxt;
  logic         w_acc;
  logic         w_xfer;
  logic         w_load_main;
  logic         w_load_skid;
  logic         w_main_from_skid;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY: if (w_acc) w_state_nxt = ONE;
      ONE: begin
        if (w_acc && !w_xfer)      w_state_nxt = FULL;
        else if (!w_acc && w_xfer) w_state_nxt = EMPTY;
      end
      FULL:    if (w_xfer) w_state_nxt = ONE;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Main always drives the outputs; skid only absorbs the one result that
  // arrives while main is stalled.
  always_comb begin
    o_in_ready       = (r_state != FULL);
    o_out_valid      = (r_state != EMPTY);
    w_acc            = i_in_valid && (r_state != FULL);
    w_xfer           = i_out_ready && (r_state != EMPTY);
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    unique case (r_state)
      EMPTY:   w_load_main      = w_acc;
      ONE: begin
        w_load_main = w_acc && w_xfer;
        w_load_skid = w_acc && !w_xfer;
      end
      FULL:    w_main_from_skid = w_xfer;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main)           r_main <= i_in_data;
      else if (w_main_from_skid) r_main <= r_skid;
      if (w_load_skid)           r_skid <= i_in_data;
    end
  end

  assign o_out_data = r_main;

endmodule

// File: rtl/wb_src_mux.sv
// Write-back source selector: picks one of NUM_SRC buses at accept, flags
// out-of-range selects in a sticky error bit and delivers through a skid stage.
module wb_src_mux
  import wb_mux_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [NUM_SRC*DATA_W-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [SEL_W-1:0]          out_src,
  output logic                      err_sel,
  input  logic                      err_clr
);

  localparam int PL_W = DATA_W + SEL_W;

  if (NUM_SRC < NUM_SRC_MIN || NUM_SRC > NUM_SRC_MAX) begin : g_bad_num_src
    $error("wb_src_mux: NUM_SRC out of legal range");
  end

  logic              w_in_range;
  logic              w_accept;
  logic [DATA_W-1:0] w_sel_data;
  logic [PL_W-1:0]   w_out_payload;
  logic              r_err_sel;

  // Unmatched selects fall through to zero data.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (in_sel == SEL_W'(k)) w_sel_data = in_data[k*DATA_W +: DATA_W];
    end
  end

  assign w_in_range = sel_in_range(32'(in_sel), NUM_SRC);
  assign w_accept   = in_valid && in_ready;

  // Set takes priority over clear so an error in the clearing cycle is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sel <= 1'b0;
    end else if (w_accept && !w_in_range) begin
      r_err_sel <= 1'b1;
    end else if (err_clr) begin
      r_err_sel <= 1'b0;
    end
  end

  wb_skid_reg #(
    .W (PL_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   ({w_sel_data, in_sel}),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (w_out_payload)
  );

  assign out_data = w_out_payload[PL_W-1 -: DATA_W];
  assign out_src  = w_out_payload[SEL_W-1:0];
  assign err_sel  = r_err_sel;

endmodule

// File: tb/tb_wb_src_mux.sv
// Directed and randomized-sweep bench for wb_src_mux in two configurations:
// 8-bit/3-source (instance A) and 16-bit/5-source (instance B).
module tb_wb_src_mux;

  localparam int A_DW = 8;
  localparam int A_NS = 3;
  localparam int A_SW = 2;
  localparam int B_DW = 16;
  localparam int B_NS = 5;
  localparam int B_SW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err_sel, a_err_clr;
  logic [A_SW-1:0]      a_in_sel, a_out_src;
  logic [A_NS*A_DW-1:0] a_in_data;
  logic [A_DW-1:0]      a_out_data;

  logic                 b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err_sel, b_err_clr;
  logic [B_SW-1:0]      b_in_sel, b_out_src;
  logic [B_NS*B_DW-1:0] b_in_data;
  logic [B_DW-1:0]      b_out_data;

  int checks = 0;
  int errors = 0;

  wb_src_mux #(.DATA_W(A_DW), .NUM_SRC(A_NS)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_sel(a_in_sel), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_src(a_out_src),
    .err_sel(a_err_sel), .err_clr(a_err_clr)
  );

  wb_src_mux #(.DATA_W(B_DW), .NUM_SRC(B_NS)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sel(b_in_sel), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_src(b_out_src),
    .err_sel(b_err_sel), .err_clr(b_err_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_in_valid = 1'b1; a_in_sel = '0; a_in_data = {8'h33, 8'h22, 8'h11};
    a_out_ready = 1'b0; a_err_clr = 1'b0;
    b_in_valid = 1'b0; b_in_sel = '0; b_in_data = '0; b_out_ready = 1'b0; b_err_clr = 1'b0;
    #12;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", a_out_valid); end
    checks++; if (a_out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %0h want 0", a_out_data); end
    checks++; if (a_out_src !== 2'd0) begin errors++; $display("FAIL reset_out_src: got %0d want 0", a_out_src); end
    checks++; if (a_err_sel !== 1'b0) begin errors++; $display("FAIL reset_err_sel: got %0b want 0", a_err_sel); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", a_in_ready); end
    step();
    step();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_ignores_valid: got %0b want 0", a_out_valid); end
    a_in_valid = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_streaming();
    logic [7:0] exp_d [3];
    exp_d = '{8'h11, 8'h22, 8'h33};
    a_in_data = {8'h33, 8'h22, 8'h11};
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1;
      a_in_sel = 2'(i);
      step();
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %0b want 1", i, a_out_valid); end
      checks++; if (a_out_data !== exp_d[i]) begin errors++; $display("FAIL stream_data[%0d]: got %0h want %0h", i, a_out_data, exp_d[i]); end
      checks++; if (a_out_src !== 2'(i)) begin errors++; $display("FAIL stream_src[%0d]: got %0d want %0d", i, a_out_src, i); end
    end
    a_in_valid = 1'b0;
    step();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %0b want 0", a_out_valid); end
    checks++; if (a_err_sel !== 1'b0) begin errors++; $display("FAIL stream_err: got %0b want 0", a_err_sel); end
  endtask

  task automatic test_back_to_back();
    a_out_ready = 1'b0;
    a_in_sel = 2'd0;
    a_in_valid = 1'b1;
    a_in_data[7:0] = 8'hA1;
    step();
    checks++; if (a_out_data !== 8'hA1) begin errors++; $display("FAIL bp_first: got %0h want a1", a_out_data); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %0b want 1", a_in_ready); end
    a_in_data[7:0] = 8'hA2;
    step();
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %0b want 0", a_in_ready); end
    a_in_data[7:0] = 8'hA3;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %0b want 0", i, a_in_ready); end
      checks++; if (a_out_data !== 8'hA1 || a_out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold_data[%0d]: got %0h/%0b want a1/1", i, a_out_data, a_out_valid); end
    end
    a_out_ready = 1'b1;
    step();
    checks++; if (a_out_data !== 8'hA2) begin errors++; $display("FAIL bp_out2: got %0h want a2", a_out_data); end
    step();
    checks++; if (a_out_data !== 8'hA3 || a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_out3: got %0h want a3", a_out_data); end
    a_in_data[7:0] = 8'hA4;
    step();
    checks++; if (a_out_data !== 8'hA4 || a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_out4: got %0h want a4", a_out_data); end
    a_in_valid = 1'b0;
    step();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b want 0", a_out_valid); end
  endtask

  task automatic test_bad_sel();
    a_in_data = {8'h77, 8'h66, 8'h55};
    a_out_ready = 1'b1;
    a_err_clr = 1'b0;
    a_in_valid = 1'b1;
    a_in_sel = 2'd3;
    step();
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h00) begin
      errors++; $display("FAIL bad_data: got %0h/%0b want 00/1", a_out_data, a_out_valid); end
    checks++; if (a_out_src !== 2'd3) begin errors++; $display("FAIL bad_src: got %0d want 3", a_out_src); end
    checks++; if (a_err_sel !== 1'b1) begin errors++; $display("FAIL bad_err_set: got %0b want 1", a_err_sel); end
    a_err_clr = 1'b1;
    step();
    checks++; if (a_err_sel !== 1'b1) begin errors++; $display("FAIL bad_set_wins: got %0b want 1", a_err_sel); end
    a_in_valid = 1'b0;
    step();
    checks++; if (a_err_sel !== 1'b0) begin errors++; $display("FAIL bad_clear: got %0b want 0", a_err_sel); end
    a_err_clr = 1'b0;
    a_in_valid = 1'b1;
    a_in_sel = 2'd2;
    step();
    checks++; if (a_out_data !== 8'h77 || a_out_src !== 2'd2) begin
      errors++; $display("FAIL good_after_bad: got %0h/%0d want 77/2", a_out_data, a_out_src); end
    checks++; if (a_err_sel !== 1'b0) begin errors++; $display("FAIL good_no_err: got %0b want 0", a_err_sel); end
    a_in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    a_in_data = {8'h33, 8'hC5, 8'hB1};
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_in_sel = 2'd0;
    step();
    a_in_sel = 2'd3;
    step();
    checks++; if (a_in_ready !== 1'b0 || a_err_sel !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: got ready %0b err %0b want 0 1", a_in_ready, a_err_sel); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 8'h00) begin
      errors++; $display("FAIL rstmid_async: got %0b/%0h want 0/00", a_out_valid, a_out_data); end
    checks++; if (a_in_ready !== 1'b1 || a_err_sel !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctrl: got ready %0b err %0b want 1 0", a_in_ready, a_err_sel); end
    step();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_hold: got %0b want 0", a_out_valid); end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale[%0d]: got %0b want 0", i, a_out_valid); end
    end
    a_in_valid = 1'b1;
    a_in_sel = 2'd1;
    step();
    checks++; if (a_out_data !== 8'hC5 || a_out_src !== 2'd1 || a_out_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_after: got %0h/%0d want c5/1", a_out_data, a_out_src); end
    a_in_valid = 1'b0;
    step();
  endtask

  task automatic test_sweep();
    logic [B_DW+B_SW-1:0] q[$];
    logic [B_DW+B_SW-1:0] exp_pl;
    logic [B_DW-1:0]      exp_d;
    logic                 exp_err;
    logic                 acc, xf;
    int                   acc_cnt;
    int                   cyc;
    exp_err = 1'b0;
    acc_cnt = 0;
    cyc = 0;
    while ((acc_cnt < 1000 || q.size() != 0 || b_out_valid) && cyc < 20000) begin
      b_in_valid = (acc_cnt < 1000) && ($urandom_range(0, 3) != 0);
      b_in_sel = 3'($urandom_range(0, 7));
      for (int k = 0; k < B_NS; k++) b_in_data[k*B_DW +: B_DW] = 16'($urandom);
      b_out_ready = ($urandom_range(0, 2) != 0);
      b_err_clr = ($urandom_range(0, 7) == 0);
      #1;
      acc = b_in_valid && b_in_ready;
      xf = b_out_valid && b_out_ready;
      if (xf) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL sweep_extra: got %0h/%0d with nothing pending", b_out_data, b_out_src);
        end else begin
          exp_pl = q.pop_front();
          if ({b_out_data, b_out_src} !== exp_pl) begin
            errors++; $display("FAIL sweep_data: got %0h/%0d want %0h/%0d", b_out_data, b_out_src,
                               exp_pl[B_DW+B_SW-1 -: B_DW], exp_pl[B_SW-1:0]);
          end
        end
      end
      if (acc) begin
        exp_d = (b_in_sel < 3'(B_NS)) ? b_in_data[b_in_sel*B_DW +: B_DW] : '0;
        q.push_back({exp_d, b_in_sel});
        acc_cnt++;
      end
      if (acc && b_in_sel >= 3'(B_NS)) exp_err = 1'b1;
      else if (b_err_clr) exp_err = 1'b0;
      step();
      cyc++;
      checks++; if (b_err_sel !== exp_err) begin errors++; $display("FAIL sweep_err cyc %0d: got %0b want %0b", cyc, b_err_sel, exp_err); end
    end
    b_in_valid = 1'b0;
    b_err_clr = 1'b0;
    checks++; if (cyc >= 20000) begin errors++; $display("FAIL sweep_timeout: got %0d accepted want 1000", acc_cnt); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL sweep_lost: got %0d pending want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_to_back();
    test_bad_sel();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
